l2_arbiter: RTL and testbench
=============================

// Module: l2_arbiter
// PURPOSE
//  Sits directly upstream of the L2 cache and multiplexes the two L1 line ports onto its single line interface.
//  - Instruction cache: read-only. Data cache: read/write.
//  - One L2 transaction is in flight at a time.
//  - Requests are captured into registers, so L2 sees stable inputs while the L1 is stalled.
//  - Read data is registered and returned with a one-cycle response pulse.
//  - Ties are broken round-robin, so neither L1 can starve the other.
// PARAMETERS
//  s_offset  5    line offset bits; forced to zero in mem_address
//  s_line    256  line width in bits (all data buses)
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       asynchronous, active-low reset
//  i_address    in   32      icache request address
//  i_read       in   1       icache line read request (level, held until i_resp)
//  i_rdata      out  s_line  line returned to icache; valid while i_resp=1
//  i_resp       out  1       one-cycle completion pulse to icache
//  d_address    in   32      dcache request address
//  d_read       in   1       dcache line read request (level)
//  d_write      in   1       dcache line write-back request (level)
//  d_wdata      in   s_line  dcache write-back line
//  d_rdata      out  s_line  line returned to dcache; valid while d_resp=1
//  d_resp       out  1       one-cycle completion pulse to dcache
//  mem_address  out  32      to L2: {captured addr[31:s_offset], s_offset'b0}
//  mem_wdata    out  s_line  to L2: captured write line
//  mem_read     out  1       to L2: read strobe, registered, held until mem_resp
//  mem_write    out  1       to L2: write strobe, registered, held until mem_resp
//  mem_rdata    in   s_line  from L2: read line, valid with mem_resp
//  mem_resp     in   1       from L2: completion
// BEHAVIOUR
//  Reset (rst=0, async)
//  - State goes to IDLE and last_grant to DCACHE.
//  - All outputs go to 0: i_resp, d_resp, mem_read, mem_write, mem_address, mem_wdata, i_rdata, d_rdata.
//  - Reset during a transaction abandons it with no response. L2 is reset by the same rst.
//  FSM states: IDLE, BUSY_I, BUSY_D, DONE.
//  IDLE: arbitration
//  - Only icache requests: grant I. Only dcache requests (d_read|d_write): grant D.
//  - Both request: grant the port that is not last_grant.
//  - On grant, register the following and go to BUSY_x:
//    - aligned address;
//    - operation: write if d_write, else read; d_read & d_write together resolve as write;
//    - d_wdata (for a D write).
//  - last_grant updates to the granted port.
//  - mem_resp is ignored while in IDLE.
//  BUSY_x
//  - mem_read/mem_write are asserted from the cycle after the grant and held constant until mem_resp=1.
//  - Client input changes are ignored; the captured values drive L2.
//  - On mem_resp=1:
//    - reads capture mem_rdata into the granted port's rdata register;
//    - mem_read/mem_write drop at that edge;
//    - state goes to DONE.
//  DONE
//  - Exactly one cycle: granted port's *_resp=1, rdata is valid, the other port's resp=0.
//  - Then IDLE.
//  - The L1 drops its request on the edge ending DONE, so there are no duplicate grants.
//  - rdata registers hold their value until the next read completes on that port.
//  Timing
//  - Latency, request-to-resp = L2 latency + 2 cycles: 1 grant cycle + 1 DONE cycle.
//  - Best case: mem_resp in the first BUSY cycle gives resp 3 cycles after the request.
//  Constraints and error cases
//  - No combinational path from any input to any output.
//  - An icache write cannot occur (no port).
//  - mem_resp while no strobe is asserted has no effect.
// TESTING
//  1. Reset: hold rst=0 while driving requests -> all outputs 0. Release -> first grant occurs next cycle.
//  2. Lone I read: i_address=0x0000_1234; L2 responds after 4 cycles with 0xA5..A5.
//     -> mem_address=0x0000_1220, mem_read=1 for 4 cycles, i_resp pulses once, i_rdata=0xA5..A5.
//  3. Lone D write: d_address=0x8000_00FF, d_wdata=0xDEAD..BEEF.
//     -> mem_write=1, mem_address=0x8000_00E0, mem_wdata=0xDEAD..BEEF; d_resp=1 one cycle; i_resp stays 0.
//  4. Tie: i_read and d_read both held from reset.
//     -> I served first, D second, then alternation I/D/I/D on continuous ties; no port served twice in a row.
//  5. Input churn: change d_address/d_wdata mid-transaction -> mem_address and mem_wdata unchanged until resp.
//  6. Abort: assert rst=0 during BUSY_D -> mem_write drops immediately; no d_resp ever issued for that request.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 line interface between the instruction
// cache (read-only) and the data cache (read/write-back). One L2 transaction
// is in flight at a time. Requests are captured into registers so that L2
// sees stable inputs. Read data is registered and returned with a one-cycle
// response pulse. When both L1s request at once, the port that was not
// granted last wins.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   i_address, i_read        icache line read request (level)
//   i_rdata, i_resp          icache returned line / one-cycle completion pulse
//   d_address, d_read,
//   d_write, d_wdata         dcache line read / write-back request (level)
//   d_rdata, d_resp          dcache returned line / one-cycle completion pulse
//   mem_address, mem_wdata,
//   mem_read, mem_write      registered request to L2, held until mem_resp
//   mem_rdata, mem_resp      L2 read line and completion
module l2_arbiter #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_address,
    input  logic              i_read,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;
    typedef enum logic {PORT_I, PORT_D} port_e;

    state_e            state_q, state_d;
    port_e             last_grant_q, last_grant_d;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic [s_line-1:0] i_rdata_q, i_rdata_d;
    logic [s_line-1:0] d_rdata_q, d_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;

    logic              i_req;
    logic              d_req;
    logic              pick_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        // Response pulses are only raised on the BUSY->DONE edge, so they
        // are high for exactly the DONE cycle.
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;

        i_req  = i_read;
        d_req  = d_read | d_write;
        // D wins when it is the only requester, or on a tie when I was last.
        pick_d = d_req & (~i_req | (last_grant_q == PORT_I));

        case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    if (pick_d) begin
                        addr_d       = {d_address[31:s_offset], {s_offset{1'b0}}};
                        // read+write together resolves as a write-back
                        mem_write_d  = d_write;
                        mem_read_d   = ~d_write;
                        if (d_write) begin
                            wdata_d = d_wdata;
                        end
                        last_grant_d = PORT_D;
                        state_d      = BUSY_D;
                    end else begin
                        addr_d       = {i_address[31:s_offset], {s_offset{1'b0}}};
                        mem_write_d  = 1'b0;
                        mem_read_d   = 1'b1;
                        last_grant_d = PORT_I;
                        state_d      = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp & (mem_read_q | mem_write_q)) begin
                    if (mem_read_q) begin
                        if (state_q == BUSY_D) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_resp_d    = (state_q == BUSY_I);
                    d_resp_d    = (state_q == BUSY_D);
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign i_rdata     = i_rdata_q;
    assign i_resp      = i_resp_q;
    assign d_rdata     = d_rdata_q;
    assign d_resp      = d_resp_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: self-checking bench for l2_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge. Directed table of single
// transactions, hand-written reset / tie / abort sequences, then a random
// phase checked against a transaction-level reference model.
module tb_l2_arbiter;

    localparam logic [31:0] AMASK = 32'hFFFF_FFE0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  i_address = '0;
    logic         i_read = 1'b0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_address = '0;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    always #5 clk = ~clk;

    l2_arbiter #(.s_offset(5), .s_line(256)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;

    // bench-side expectation of the sticky registers
    logic [255:0] exp_wd = '0;
    logic [255:0] exp_ir = '0;
    logic [255:0] exp_dr = '0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_all_zero(input string name);
        chk1({name, " mem_read"}, mem_read, 1'b0);
        chk1({name, " mem_write"}, mem_write, 1'b0);
        chk1({name, " i_resp"}, i_resp, 1'b0);
        chk1({name, " d_resp"}, d_resp, 1'b0);
        chk32({name, " mem_address"}, mem_address, 32'h0);
        chk256({name, " mem_wdata"}, mem_wdata, '0);
        chk256({name, " i_rdata"}, i_rdata, '0);
        chk256({name, " d_rdata"}, d_rdata, '0);
    endtask

    task automatic wait_strobe(input string name);
        int unsigned n = 0;
        while (!(mem_read || mem_write) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk1({name, " strobe_timeout"}, mem_read | mem_write, 1'b1);
    endtask

    typedef struct {
        bit           is_d;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int unsigned  lat;
        bit           churn;
        logic [31:0]  exp_addr;
        bit           exp_rd;
        bit           exp_wr;
    } vec_t;

    vec_t tbl[7];

    // Called right after a falling edge; returns right after a falling edge.
    task automatic run_txn(input vec_t v, input string tag);
        if (v.is_d) begin
            d_address = v.addr;
            d_wdata   = v.wdata;
            d_read    = v.rd;
            d_write   = v.wr;
        end else begin
            i_address = v.addr;
            i_read    = 1'b1;
        end
        if (v.exp_wr) exp_wd = v.wdata;
        @(negedge clk);
        for (int unsigned k = 0; k <= v.lat; k++) begin
            chk1({tag, " busy mem_read"}, mem_read, v.exp_rd);
            chk1({tag, " busy mem_write"}, mem_write, v.exp_wr);
            chk32({tag, " busy mem_address"}, mem_address, v.exp_addr);
            chk256({tag, " busy mem_wdata"}, mem_wdata, exp_wd);
            chk1({tag, " busy i_resp"}, i_resp, 1'b0);
            chk1({tag, " busy d_resp"}, d_resp, 1'b0);
            if (v.churn) begin
                d_address = $urandom;
                d_wdata   = rand_line();
                i_address = $urandom;
            end
            if (k == v.lat) begin
                mem_resp  = 1'b1;
                mem_rdata = v.rdata;
            end
            @(negedge clk);
        end
        mem_resp  = 1'b0;
        mem_rdata = rand_line();
        if (v.exp_rd) begin
            if (v.is_d) exp_dr = v.rdata;
            else        exp_ir = v.rdata;
        end
        chk1({tag, " done i_resp"}, i_resp, !v.is_d);
        chk1({tag, " done d_resp"}, d_resp, v.is_d);
        chk256({tag, " done i_rdata"}, i_rdata, exp_ir);
        chk256({tag, " done d_rdata"}, d_rdata, exp_dr);
        chk1({tag, " done mem_read"}, mem_read, 1'b0);
        chk1({tag, " done mem_write"}, mem_write, 1'b0);
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        @(negedge clk);
        chk1({tag, " after i_resp"}, i_resp, 1'b0);
        chk1({tag, " after d_resp"}, d_resp, 1'b0);
        chk1({tag, " after mem_read"}, mem_read | mem_write, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // random-phase reference model state
        bit           i_pend, d_pend, d_wr, who_d, last_d, armed;
        bit           e_rd, e_wr, e_iresp, e_dresp;
        logic [31:0]  ia, da, e_addr;
        logic [255:0] dw, e_wd, e_ir, e_dr;
        int unsigned  ph, cnt;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, '0, {8{32'hA5A5_A5A5}}, 3, 1'b0, 32'h0000_1220, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h8000_00FF, {8{32'hDEAD_BEEF}}, '0, 0, 1'b0, 32'h8000_00E0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_003F, '0, {8{32'h5A5A_0F0F}}, 1, 1'b0, 32'h0000_0020, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, {8{32'h0123_4567}}, '0, 2, 1'b0, 32'h1234_5660, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, {8{32'h89AB_CDEF}}, '0, 3, 1'b1, 32'hCAFE_F000, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, '0, {8{32'h3C3C_C3C3}}, 2, 1'b1, 32'hFFFF_FFE0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, '0, {8{32'hFFFF_0000}}, 0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        // Reset held with both ports requesting: everything stays zero.
        #1 rst = 1'b0;
        i_address = 32'h0000_0100;
        d_address = 32'h0000_0213;
        i_read    = 1'b1;
        d_read    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_all_zero("reset");
        end
        rst = 1'b1;
        @(negedge clk);
        chk1("first_grant mem_read", mem_read, 1'b1);
        chk32("first_grant mem_address", mem_address, 32'h0000_0100);

        // Continuous tie: I first (last_grant resets to D), then strict alternation.
        for (int n = 0; n < 6; n++) begin
            bit           exp_d;
            logic [255:0] line;
            exp_d = (n % 2) == 1;
            line  = rand_line();
            wait_strobe("tie");
            chk32("tie mem_address", mem_address, exp_d ? 32'h0000_0200 : 32'h0000_0100);
            chk1("tie mem_read", mem_read, 1'b1);
            mem_resp  = 1'b1;
            mem_rdata = line;
            @(negedge clk);
            mem_resp = 1'b0;
            if (exp_d) exp_dr = line;
            else       exp_ir = line;
            chk1("tie i_resp", i_resp, !exp_d);
            chk1("tie d_resp", d_resp, exp_d);
            chk256("tie i_rdata", i_rdata, exp_ir);
            chk256("tie d_rdata", d_rdata, exp_dr);
        end
        i_read = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("tie idle strobe", mem_read | mem_write, 1'b0);

        // Directed single transactions.
        for (int t = 0; t < 7; t++) begin
            run_txn(tbl[t], $sformatf("vec%0d", t));
        end

        // Abort: reset in the middle of a D write-back.
        d_address = 32'h4000_0047;
        d_wdata   = rand_line();
        d_write   = 1'b1;
        @(negedge clk);
        chk1("abort busy mem_write", mem_write, 1'b1);
        chk32("abort busy mem_address", mem_address, 32'h4000_0040);
        #1 rst = 1'b0;
        #1;
        chk1("abort mem_write", mem_write, 1'b0);
        chk32("abort mem_address", mem_address, 32'h0);
        chk256("abort d_rdata", d_rdata, '0);
        d_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_resp = 1'b1;
            @(negedge clk);
            chk1("abort no d_resp", d_resp, 1'b0);
            chk1("abort no strobe", mem_read | mem_write, 1'b0);
        end
        mem_resp = 1'b0;

        // Random phase against a transaction-level model.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        i_pend = 0; d_pend = 0; d_wr = 0; who_d = 0; last_d = 1; armed = 0;
        e_rd = 0; e_wr = 0; e_iresp = 0; e_dresp = 0;
        ia = '0; da = '0; e_addr = '0; dw = '0; e_wd = '0; e_ir = '0; e_dr = '0;
        ph = 0; cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk1("rnd mem_read", mem_read, e_rd);
            chk1("rnd mem_write", mem_write, e_wr);
            chk32("rnd mem_address", mem_address, e_addr);
            chk256("rnd mem_wdata", mem_wdata, e_wd);
            chk1("rnd i_resp", i_resp, e_iresp);
            chk1("rnd d_resp", d_resp, e_dresp);
            chk256("rnd i_rdata", i_rdata, e_ir);
            chk256("rnd d_rdata", d_rdata, e_dr);

            // L1 clients: hold a request until its response, then maybe issue another.
            if (e_iresp) i_pend = 0;
            if (e_dresp) d_pend = 0;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                ia     = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                da     = $urandom;
                d_wr   = 1'($urandom_range(0, 1));
                dw     = rand_line();
            end
            i_read    = i_pend;
            i_address = i_pend ? ia : $urandom;
            d_write   = d_pend && d_wr;
            d_read    = d_pend && (!d_wr || $urandom_range(0, 1) == 1);
            d_address = d_pend ? da : $urandom;
            d_wdata   = d_pend ? dw : rand_line();

            // L2: random latency 0..3 cycles; stray responses while idle.
            if (e_rd || e_wr) begin
                if (!armed) begin
                    armed = 1;
                    cnt   = $urandom_range(0, 3);
                end
                if (cnt == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rand_line();
                end else begin
                    cnt--;
                    mem_resp = 1'b0;
                end
            end else begin
                armed     = 0;
                mem_resp  = ($urandom_range(0, 3) == 0);
                mem_rdata = rand_line();
            end

            // Reference: what the outputs must be after the coming rising edge.
            case (ph)
                0: begin
                    if (i_pend || d_pend) begin
                        who_d  = d_pend && (!i_pend || !last_d);
                        last_d = who_d;
                        if (who_d) begin
                            e_wr   = d_wr;
                            e_rd   = !d_wr;
                            e_addr = da & AMASK;
                            if (d_wr) e_wd = dw;
                        end else begin
                            e_rd   = 1;
                            e_wr   = 0;
                            e_addr = ia & AMASK;
                        end
                        ph = 1;
                    end
                end
                1: begin
                    if (mem_resp) begin
                        if (e_rd) begin
                            if (who_d) e_dr = mem_rdata;
                            else       e_ir = mem_rdata;
                        end
                        e_rd    = 0;
                        e_wr    = 0;
                        e_iresp = !who_d;
                        e_dresp = who_d;
                        ph      = 2;
                    end
                end
                default: begin
                    e_iresp = 0;
                    e_dresp = 0;
                    ph      = 0;
                end
            endcase
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
